conv3x3_pixel_source: RTL and testbench

CONV3X3_PIXEL_SOURCE -- requirements
Module: conv3x3_pixel_source

---
 rtl/conv3x3_pixel_source.sv | 199 +++++++++++++++++++
 tb/tb_conv3x3_pixel_source.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_pixel_source.sv
// 3x3 convolution pixel source: maps a VGA screen request onto an upscaled source image,
// fetches the 9-tap neighbourhood from RAM, and returns one saturated 4-bit filtered pixel.
module conv3x3_pixel_source #(
    parameter int SRC_W       = 160,
    parameter int SRC_H       = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_request,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [1:0]  kernel_sel,
    output logic [3:0]  grayscale_pixel,
    output logic        pixel_valid,
    output logic        busy,
    output logic        mem_en,
    output logic [14:0] mem_addr,
    input  logic [3:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, FINISH} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [9:0]         sx_q, sy_q;
    logic [1:0]         k_q;
    logic signed [11:0] acc_q;

    logic               pend_valid_q;
    logic [9:0]         pend_x_q, pend_y_q;
    logic [1:0]         pend_k_q;

    logic               cache_valid_q;
    logic [9:0]         cache_sx_q, cache_sy_q;
    logic [1:0]         cache_k_q;
    logic [3:0]         cache_pix_q;

    // Tap t is row-major over the 3x3 window; borders replicate the nearest source pixel.
    function automatic logic [14:0] tap_addr(input logic [9:0] sx, input logic [9:0] sy,
                                             input logic [3:0] tap);
        int col;
        int row;
        col = int'(sx) + int'(tap % 4'd3) - 1;
        row = int'(sy) + int'(tap / 4'd3) - 1;
        if (col < 0) col = 0;
        else if (col > SRC_W - 1) col = SRC_W - 1;
        if (row < 0) row = 0;
        else if (row > SRC_H - 1) row = SRC_H - 1;
        return 15'(row * SRC_W + col);
    endfunction

    function automatic logic signed [4:0] tap_weight(input logic [1:0] k, input logic [3:0] tap);
        logic centre;
        logic corner;
        centre = (tap == 4'd4);
        corner = (tap == 4'd0) || (tap == 4'd2) || (tap == 4'd6) || (tap == 4'd8);
        case (k)
            2'd0:    return centre ? 5'sd1 : 5'sd0;
            2'd1:    return centre ? 5'sd4 : (corner ? 5'sd1 : 5'sd2);
            2'd2:    return centre ? 5'sd5 : (corner ? 5'sd0 : -5'sd1);
            default: return centre ? 5'sd8 : -5'sd1;
        endcase
    endfunction

    // Request arbitration: IDLE takes the live request; FINISH prefers a live request over the held one.
    logic       req_v;
    logic [9:0] req_x, req_y, req_sx, req_sy;
    logic [1:0] req_k;
    logic       req_oor, req_hit;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        req_v = 1'b0;
        req_x = pixel_x;
        req_y = pixel_y;
        req_k = kernel_sel;
        case (state_q)
            IDLE:   req_v = pixel_request;
            FINISH: begin
                if (pixel_request) begin
                    req_v = 1'b1;
                end else if (pend_valid_q) begin
                    req_v = 1'b1;
                    req_x = pend_x_q;
                    req_y = pend_y_q;
                    req_k = pend_k_q;
                end
            end
            default: ;
        endcase
    end

    assign req_sx  = req_x >> SCALE_SHIFT;
    assign req_sy  = req_y >> SCALE_SHIFT;
    assign req_oor = (req_x >= 10'd640) || (req_y >= 10'd480);
    assign req_hit = cache_valid_q && !req_oor && (req_sx == cache_sx_q) &&
                     (req_sy == cache_sy_q) && (req_k == cache_k_q);

    // Data arriving this cycle belongs to the tap issued one cycle earlier.
    logic [3:0]         dtap;
    logic signed [11:0] w_ext, d_ext, prod, sum, res;
    logic [3:0]         fin_pix;

    always_comb begin
        dtap  = cnt_q - 4'd1;
        w_ext = 12'(tap_weight(k_q, dtap));
        d_ext = $signed({8'd0, mem_rdata});
        prod  = w_ext * d_ext;
        sum   = acc_q + prod;
        res   = (k_q == 2'd1) ? (sum >>> 4) : sum;
        if (res < 0)              fin_pix = 4'd0;
        else if (res > 12'sd15)   fin_pix = 4'd15;
        else                      fin_pix = res[3:0];
    end

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            sx_q            <= '0;
            sy_q            <= '0;
            k_q             <= '0;
            acc_q           <= '0;
            pend_valid_q    <= 1'b0;
            pend_x_q        <= '0;
            pend_y_q        <= '0;
            pend_k_q        <= '0;
            cache_valid_q   <= 1'b0;
            cache_sx_q      <= '0;
            cache_sy_q      <= '0;
            cache_k_q       <= '0;
            cache_pix_q     <= '0;
            grayscale_pixel <= '0;
            pixel_valid     <= 1'b0;
            busy            <= 1'b0;
            mem_en          <= 1'b0;
            mem_addr        <= '0;
        end else begin
            pixel_valid <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (pixel_request) begin
                        pend_valid_q <= 1'b1;
                        pend_x_q     <= pixel_x;
                        pend_y_q     <= pixel_y;
                        pend_k_q     <= kernel_sel;
                    end
                    if (cnt_q < 4'd8) begin
                        mem_en   <= 1'b1;
                        mem_addr <= tap_addr(sx_q, sy_q, cnt_q + 4'd1);
                    end else begin
                        mem_en   <= 1'b0;
                    end
                    if (cnt_q != 4'd0) acc_q <= sum;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        grayscale_pixel <= fin_pix;
                        pixel_valid     <= 1'b1;
                        cache_valid_q   <= 1'b1;
                        cache_sx_q      <= sx_q;
                        cache_sy_q      <= sy_q;
                        cache_k_q       <= k_q;
                        cache_pix_q     <= fin_pix;
                        state_q         <= FINISH;
                    end
                end
                default: begin
                    // IDLE and FINISH both accept work; FINISH always consumes the held request.
                    if (state_q == FINISH) pend_valid_q <= 1'b0;
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    if (req_v) begin
                        if (req_oor) begin
                            grayscale_pixel <= 4'd0;
                            pixel_valid     <= 1'b1;
                        end else if (req_hit) begin
                            // Restoring the cached value keeps a hit correct even after an out-of-range 0.
                            grayscale_pixel <= cache_pix_q;
                            pixel_valid     <= 1'b1;
                        end else begin
                            state_q  <= FETCH;
                            busy     <= 1'b1;
                            sx_q     <= req_sx;
                            sy_q     <= req_sy;
                            k_q      <= req_k;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= tap_addr(req_sx, req_sy, 4'd0);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_pixel_source.sv
// Directed, table-driven bench for conv3x3_pixel_source with a 1-cycle-latency RAM model.
module tb_conv3x3_pixel_source;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pixel_request = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [1:0]  kernel_sel = '0;
    logic [3:0]  grayscale_pixel;
    logic        pixel_valid;
    logic        busy;
    logic        mem_en;
    logic [14:0] mem_addr;
    logic [3:0]  mem_rdata = '0;

    conv3x3_pixel_source dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_request  (pixel_request),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .kernel_sel     (kernel_sel),
        .grayscale_pixel(grayscale_pixel),
        .pixel_valid    (pixel_valid),
        .busy           (busy),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [3:0] ram [0:19199];
    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t_req = 0;
    int         vcyc[$];
    logic [3:0] vpix[$];
    int         rcyc[$];
    int         raddr[$];

    typedef struct {
        int ctr;
        int edg;
        int corner;
        int k;
        int exp_pix;
    } vec_t;
    vec_t vecs[20];

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_en) begin
            rcyc.push_back(cyc);
            raddr.push_back(int'(mem_addr));
        end
        if (pixel_valid) begin
            vcyc.push_back(cyc);
            vpix.push_back(grayscale_pixel);
        end
    endtask

    task automatic clear_logs();
        vcyc.delete(); vpix.delete(); rcyc.delete(); raddr.delete();
    endtask

    task automatic send(input int x, input int y, input int k);
        step();
        pixel_request = 1'b1;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        kernel_sel = 2'(k);
        t_req = cyc;
        step();
        pixel_request = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int a = 0; a < 19200; a++) ram[a] = 4'(v);
    endtask

    function automatic int lat(input int i);
        return (vcyc.size() > i) ? vcyc[i] - t_req : -1;
    endfunction
    function automatic int pix(input int i);
        return (vpix.size() > i) ? int'(vpix[i]) : -1;
    endfunction
    function automatic int radr(input int i);
        return (raddr.size() > i) ? raddr[i] : -1;
    endfunction
    function automatic int rlat(input int i);
        return (rcyc.size() > i) ? rcyc[i] - t_req : -1;
    endfunction

    initial begin
        vecs = '{
            '{7, 7, 7, 1, 7},   '{9, 3, 3, 0, 9},   '{8, 4, 4, 1, 5},   '{6, 2, 2, 1, 3},
            '{5, 2, 2, 2, 15},  '{4, 3, 3, 2, 8},   '{2, 3, 3, 2, 0},   '{15, 0, 0, 3, 15},
            '{0, 15, 15, 3, 0}, '{9, 8, 8, 3, 8},   '{3, 3, 3, 3, 0},   '{15, 15, 15, 1, 15},
            '{1, 15, 15, 2, 0}, '{15, 14, 14, 2, 15}, '{6, 5, 5, 2, 10}, '{10, 9, 9, 1, 9},
            '{0, 8, 0, 1, 4},   '{3, 1, 15, 2, 11}, '{3, 2, 1, 3, 12},  '{2, 15, 0, 0, 2}
        };

        // Reset state
        repeat (3) step();
        #1;
        check("rst_pix", int'(grayscale_pixel), 0);
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mem_en", int'(mem_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        step();
        reset = 1'b1;
        repeat (2) step();

        // Uniform 7, gaussian at (100,60): centre tap address and full timing
        fill(7);
        clear_logs();
        send(100, 60, 1);
        check("a_busy", int'(busy), 1);
        repeat (12) step();
        check("a_reads", rcyc.size(), 9);
        check("a_centre_addr", radr(4), 15 * 160 + 25);
        check("a_first_read", rlat(0), 1);
        check("a_last_read", rlat(8), 9);
        check("a_lat", lat(0), 11);
        check("a_pix", pix(0), 7);
        check("a_busy_done", int'(busy), 0);

        // Same source pixel and kernel: cache hit
        clear_logs();
        send(101, 61, 1);
        repeat (4) step();
        check("hit_reads", rcyc.size(), 0);
        check("hit_lat", lat(0), 1);
        check("hit_pix", pix(0), 7);

        // Table of 3x3 neighbourhoods with centre/edge/corner values
        fill(0);
        for (int i = 0; i < 20; i++) begin
            int sx;
            int sy;
            sx = 10 + 3 * i;
            sy = 30;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    ram[(sy + dy) * 160 + sx + dx] =
                        (dx == 0 && dy == 0) ? 4'(vecs[i].ctr) :
                        (dx == 0 || dy == 0) ? 4'(vecs[i].edg) : 4'(vecs[i].corner);
            clear_logs();
            send(sx * 4 + i % 4, sy * 4 + i % 3, vecs[i].k);
            repeat (12) step();
            check($sformatf("vec%0d_pix", i), pix(0), vecs[i].exp_pix);
            check($sformatf("vec%0d_lat", i), lat(0), 11);
            check($sformatf("vec%0d_reads", i), rcyc.size(), 9);
        end

        // Top-left corner clamping, identity
        fill(0);
        ram[0] = 4'd9;
        clear_logs();
        send(0, 0, 0);
        repeat (12) step();
        begin
            int exp_a[9];
            exp_a = '{0, 0, 1, 0, 0, 1, 160, 160, 161};
            for (int i = 0; i < 9; i++) check($sformatf("tl_addr%0d", i), radr(i), exp_a[i]);
        end
        check("tl_pix", pix(0), 9);

        // Bottom-right corner clamping
        ram[19199] = 4'd5;
        clear_logs();
        send(639, 479, 0);
        repeat (12) step();
        check("br_first_addr", radr(0), 118 * 160 + 158);
        check("br_last_addr", radr(8), 19199);
        check("br_pix", pix(0), 5);

        // Out-of-range requests
        clear_logs();
        send(700, 10, 1);
        repeat (3) step();
        check("oor_x_lat", lat(0), 1);
        check("oor_x_pix", pix(0), 0);
        check("oor_x_reads", rcyc.size(), 0);
        clear_logs();
        send(10, 480, 0);
        repeat (3) step();
        check("oor_y_lat", lat(0), 1);
        check("oor_y_reads", rcyc.size(), 0);

        // Two requests while busy: only the newer one runs after FINISH
        fill(7);
        ram[10 * 160 + 10] = 4'd3;
        ram[20 * 160 + 20] = 4'd5;
        ram[30 * 160 + 30] = 4'd11;
        clear_logs();
        send(40, 40, 0);
        step();
        pixel_request = 1'b1; pixel_x = 10'd80; pixel_y = 10'd80; kernel_sel = 2'd0;
        step();
        pixel_request = 1'b0;
        step();
        pixel_request = 1'b1; pixel_x = 10'd120; pixel_y = 10'd120; kernel_sel = 2'd0;
        step();
        pixel_request = 1'b0;
        repeat (25) step();
        check("pend_valids", vcyc.size(), 2);
        check("pend_first_lat", lat(0), 11);
        check("pend_first_pix", pix(0), 3);
        check("pend_second_lat", lat(1), 22);
        check("pend_second_pix", pix(1), 11);
        check("pend_reads", rcyc.size(), 18);

        // Reset asserted at T+5 of a fetch
        ram[12 * 160 + 12] = 4'd2;
        clear_logs();
        send(48, 48, 0);
        repeat (4) step();
        reset = 1'b0;
        #1;
        check("abort_pix", int'(grayscale_pixel), 0);
        check("abort_valid", int'(pixel_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_mem_en", int'(mem_en), 0);
        check("abort_addr", int'(mem_addr), 0);
        clear_logs();
        repeat (2) step();
        reset = 1'b1;
        repeat (20) step();
        check("abort_no_valid", vcyc.size(), 0);
        check("abort_no_reads", rcyc.size(), 0);

        // Cache was invalidated: the last completed request must refetch
        clear_logs();
        send(120, 120, 0);
        repeat (12) step();
        check("post_rst_lat", lat(0), 11);
        check("post_rst_pix", pix(0), 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
